// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM: byte-masked writes on port 0, reads on both ports,
// 1- or 2-cycle registered read path carrying data, valid and collision.
module sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en, rd0_en, rd1_en, hit;
  logic [DATA_WIDTH-1:0] rd1_word;

  logic                  s1_v0_q, s1_v0_d;
  logic [DATA_WIDTH-1:0] s1_d0_q, s1_d0_d;
  logic                  s1_v1_q, s1_v1_d;
  logic [DATA_WIDTH-1:0] s1_d1_q, s1_d1_d;
  logic                  s1_col_q, s1_col_d;

  // Requests presented during reset are dropped, writes included.
  assign wr_en  = !rst && !csb0 && !web0;
  assign rd0_en = !rst && !csb0 &&  web0;
  assign rd1_en = !rst && !csb1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // Port-1 read word; with bypass the masked lanes of a same-address write are forwarded.
  always_comb begin
    hit      = wr_en && rd1_en && (addr0 == addr1);
    rd1_word = mem_q[addr1];
    if ((BYPASS != 0) && hit) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) rd1_word[8*i +: 8] = din0[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_v0_d  = rd0_en;
    s1_d0_d  = rd0_en ? mem_q[addr0] : s1_d0_q;
    s1_v1_d  = rd1_en;
    s1_d1_d  = rd1_en ? rd1_word : s1_d1_q;
    s1_col_d = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v0_q  <= 1'b0;
      s1_d0_q  <= '0;
      s1_v1_q  <= 1'b0;
      s1_d1_q  <= '0;
      s1_col_q <= 1'b0;
    end else begin
      s1_v0_q  <= s1_v0_d;
      s1_d0_q  <= s1_d0_d;
      s1_v1_q  <= s1_v1_d;
      s1_d1_q  <= s1_d1_d;
      s1_col_q <= s1_col_d;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_v0_q, s2_v0_d;
    logic [DATA_WIDTH-1:0] s2_d0_q, s2_d0_d;
    logic                  s2_v1_q, s2_v1_d;
    logic [DATA_WIDTH-1:0] s2_d1_q, s2_d1_d;
    logic                  s2_col_q, s2_col_d;

    // Output data only advances on a valid stage-1 result so dout holds between reads.
    always_comb begin
      s2_v0_d  = s1_v0_q;
      s2_d0_d  = s1_v0_q ? s1_d0_q : s2_d0_q;
      s2_v1_d  = s1_v1_q;
      s2_d1_d  = s1_v1_q ? s1_d1_q : s2_d1_q;
      s2_col_d = s1_col_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v0_q  <= 1'b0;
        s2_d0_q  <= '0;
        s2_v1_q  <= 1'b0;
        s2_d1_q  <= '0;
        s2_col_q <= 1'b0;
      end else begin
        s2_v0_q  <= s2_v0_d;
        s2_d0_q  <= s2_d0_d;
        s2_v1_q  <= s2_v1_d;
        s2_d1_q  <= s2_d1_d;
        s2_col_q <= s2_col_d;
      end
    end

    assign dout0       = s2_d0_q;
    assign dout0_valid = s2_v0_q;
    assign dout1       = s2_d1_q;
    assign dout1_valid = s2_v1_q;
    assign collision   = s2_col_q;
  end else begin : g_lat1
    assign dout0       = s1_d0_q;
    assign dout0_valid = s1_v0_q;
    assign dout1       = s1_d1_q;
    assign dout1_valid = s1_v1_q;
    assign collision   = s1_col_q;
  end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench for sram_1rw1r_param over three geometries/latency/bypass configurations.
module tb_sram_1rw1r_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [2:0]  done     = '0;

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DW    = (g == 2) ? 64 : 32;
    localparam int AW    = (g == 2) ? 4 : 8;
    localparam int NM    = DW / 8;
    localparam int LAT   = (g == 0) ? 1 : 2;
    localparam int BYP   = (g == 1) ? 0 : 1;
    localparam int DEPTH = 1 << AW;

    logic          rst, csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;
    logic          dout0_valid, dout1_valid, collision;

    sram_1rw1r_param #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM), .RD_LATENCY(LAT), .BYPASS(BYP)
    ) dut (
      .clk(clk), .rst(rst),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0), .dout0_valid(dout0_valid),
      .csb1(csb1), .addr1(addr1), .dout1(dout1), .dout1_valid(dout1_valid),
      .collision(collision)
    );

    logic [DW-1:0]   model [DEPTH];
    logic [DW-1:0]   q0_d[$], q1_d[$];
    logic            q1_c[$];
    longint unsigned q0_t[$], q1_t[$];
    logic [DW-1:0]   last0, last1;
    bit              started = 0;

    task automatic idle();
      csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
      csb1 = 1'b1; addr1 = '0;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [NM-1:0] m);
      csb0 = 1'b0; web0 = 1'b0; addr0 = AW'(a); din0 = DW'(d); wmask0 = m;
    endtask

    // Apply the current inputs to the reference model, then advance one clock.
    task automatic step();
      logic [DW-1:0] old1;
      logic          col;
      if (rst) begin
        @(posedge clk); #1;
        q0_d.delete(); q0_t.delete(); q1_d.delete(); q1_c.delete(); q1_t.delete();
        last0 = '0; last1 = '0; started = 1;
        chk("rst_dout0", g, 64'(dout0), 64'd0);
        chk("rst_dout1", g, 64'(dout1), 64'd0);
        chk("rst_valid0", g, 64'(dout0_valid), 64'd0);
        chk("rst_valid1", g, 64'(dout1_valid), 64'd0);
        chk("rst_collision", g, 64'(collision), 64'd0);
        return;
      end
      if (!csb1) begin
        old1 = model[addr1];
        col  = !csb0 && !web0 && (addr0 == addr1);
        if (col && BYP == 1)
          for (int i = 0; i < NM; i++) if (wmask0[i]) old1[8*i +: 8] = din0[8*i +: 8];
        q1_d.push_back(old1); q1_c.push_back(col); q1_t.push_back(cyc + LAT);
      end
      if (!csb0 && web0) begin
        q0_d.push_back(model[addr0]); q0_t.push_back(cyc + LAT);
      end
      if (!csb0 && !web0)
        for (int i = 0; i < NM; i++) if (wmask0[i]) model[addr0][8*i +: 8] = din0[8*i +: 8];
      @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
      if (started) begin
        while (q0_t.size() != 0 && q0_t[0] < cyc) begin
          chk("dout0_valid_missing", g, 64'd0, 64'd1);
          void'(q0_t.pop_front()); void'(q0_d.pop_front());
        end
        if (dout0_valid) begin
          if (q0_t.size() == 0) chk("dout0_valid_spurious", g, 64'd1, 64'd0);
          else begin
            chk("dout0_latency", g, 64'(cyc), 64'(q0_t[0]));
            chk("dout0", g, 64'(dout0), 64'(q0_d[0]));
            void'(q0_t.pop_front()); void'(q0_d.pop_front());
          end
          last0 = dout0;
        end else chk("dout0_hold", g, 64'(dout0), 64'(last0));

        while (q1_t.size() != 0 && q1_t[0] < cyc) begin
          chk("dout1_valid_missing", g, 64'd0, 64'd1);
          void'(q1_t.pop_front()); void'(q1_d.pop_front()); void'(q1_c.pop_front());
        end
        if (dout1_valid) begin
          if (q1_t.size() == 0) chk("dout1_valid_spurious", g, 64'd1, 64'd0);
          else begin
            chk("dout1_latency", g, 64'(cyc), 64'(q1_t[0]));
            chk("dout1", g, 64'(dout1), 64'(q1_d[0]));
            chk("collision", g, 64'(collision), 64'(q1_c[0]));
            void'(q1_t.pop_front()); void'(q1_d.pop_front()); void'(q1_c.pop_front());
          end
          last1 = dout1;
        end else begin
          chk("dout1_hold", g, 64'(dout1), 64'(last1));
          chk("collision_idle", g, 64'(collision), 64'd0);
        end
      end
    end

    initial begin
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;

      // Fill every word with a distinct pattern so no read ever sees an unwritten location.
      for (int a = 0; a < DEPTH; a++) begin
        wr(a, {32'(a) * 32'h9E37_79B9, ~32'(a)}, '1); step();
      end
      idle();

      if (g == 2) begin
        for (int a = 0; a < DEPTH; a++) begin
          csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a);
          csb1 = 1'b0; addr1 = AW'(a);
          step();
        end
        idle();
      end else begin
        // Byte-lane merge: expected 0x11BB33DD.
        wr(16, 64'h1122_3344, '1); step();
        wr(16, 64'hAABB_CCDD, NM'(4'h5)); step();
        idle(); csb0 = 1'b0; addr0 = AW'(16); step();
        idle(); step();

        // Collision at 0x20: bypass gives 0xCAFE0000, otherwise 0x00000000.
        wr(32, 64'h0, '1); step();
        wr(32, 64'hCAFE_F00D, NM'(4'hC)); csb1 = 1'b0; addr1 = AW'(32); step();
        idle(); step();

        // Back-to-back port-1 stream of mem[i] = i+1.
        for (int a = 0; a < 8; a++) begin wr(a, 64'(a + 1), '1); step(); end
        idle();
        for (int a = 0; a < 8; a++) begin csb1 = 1'b0; addr1 = AW'(a); step(); end
        idle(); step(); step();

        // Write attempted during reset must leave address 5 untouched.
        rst = 1'b1; wr(5, 64'hDEAD_BEEF, '1);
        step(); step();
        rst = 1'b0; idle();
        csb0 = 1'b0; addr0 = AW'(5); csb1 = 1'b0; addr1 = AW'(5); step();
        idle(); step(); step();

        // Read in flight when reset arrives.
        csb0 = 1'b0; addr0 = AW'(3); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0; step(); step(); step();
      end

      for (int n = 0; n < 400; n++) begin
        rst    = ($urandom_range(0, 49) == 0);
        csb0   = ($urandom_range(0, 3) == 0);
        web0   = $urandom_range(0, 1) == 1;
        wmask0 = NM'($urandom());
        addr0  = AW'($urandom_range(0, 7));
        din0   = DW'({$urandom(), $urandom()});
        csb1   = ($urandom_range(0, 3) == 0);
        addr1  = AW'($urandom_range(0, 7));
        step();
      end
      rst = 1'b0; idle();
      repeat (LAT + 2) step();
      chk("drain", g, 64'(q0_t.size() + q1_t.size()), 64'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      if (&done) break;
    end
    if (!(&done)) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: done flags %b expected 111", done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
